fifo_burst_reader: RTL

//  Drains fifo_sync on its read side and re-emits its contents as a valid/ready stream framed into bursts.

---
 rtl/fifo_burst_reader.sv | 117 +++++++++++
 1 files changed

// File: rtl/fifo_burst_reader.sv
// Drains a synchronous FIFO into a valid/ready stream framed into bursts of BURST_LEN beats.
// A two-entry skid buffer absorbs the FIFO's one-cycle read latency; idle partial bursts are closed by a timeout.
module fifo_burst_reader #(
  parameter int DATA_WIDTH = 8,
  parameter int BURST_LEN  = 8,
  parameter int TIMEOUT    = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  fifo_empty,
  input  logic [DATA_WIDTH-1:0] fifo_data,
  output logic                  fifo_rd,
  output logic                  m_valid,
  input  logic                  m_ready,
  output logic [DATA_WIDTH-1:0] m_data,
  output logic                  m_last,
  output logic                  busy
);
  localparam int BW = (BURST_LEN > 1) ? $clog2(BURST_LEN) : 1;
  localparam int TW = $clog2(TIMEOUT + 1);
  localparam logic [BW-1:0] LAST_BEAT = BW'(BURST_LEN - 1);
  localparam logic [TW-1:0] TIMER_MAX = TW'(TIMEOUT);

  typedef enum logic [1:0] {IDLE, ACTIVE, FLUSH} state_t;

  state_t                state_q, state_d;
  logic [DATA_WIDTH-1:0] buf0_q, buf0_d, buf1_q, buf1_d;
  logic [1:0]            count_q, count_d;
  logic                  inflight_q, inflight_d;
  logic [BW-1:0]         beat_q, beat_d;
  logic [TW-1:0]         timer_q, timer_d;

  logic       pop;
  logic [1:0] occ_after_pop;
  logic [1:0] tail_idx;
  logic       head_held;

  // A lone head word is held back unless we already know it is not the burst's last.
  always_comb begin
    m_valid = (count_q != 2'd0) &&
              ((count_q == 2'd2) || inflight_q || (beat_q == LAST_BEAT) || (state_q == FLUSH));
    m_last  = m_valid && ((beat_q == LAST_BEAT) || (state_q == FLUSH));
    m_data  = buf0_q;
    busy    = (state_q != IDLE);
    pop     = m_valid && m_ready;
    head_held = (count_q == 2'd1) && !m_valid;
  end

  always_comb begin
    occ_after_pop = count_q + {1'b0, inflight_q} - {1'b0, pop};
    fifo_rd       = rst && !fifo_empty && (state_q != FLUSH) && (occ_after_pop < 2'd2);
    tail_idx      = count_q - {1'b0, pop};
  end

  always_comb begin
    buf0_d     = buf0_q;
    buf1_d     = buf1_q;
    inflight_d = fifo_rd;
    count_d    = occ_after_pop;
    if (pop) begin
      buf0_d = buf1_q;
    end
    // The returning word lands behind whatever survives this cycle's pop.
    if (inflight_q) begin
      if (tail_idx == 2'd0) begin
        buf0_d = fifo_data;
      end else begin
        buf1_d = fifo_data;
      end
    end

    beat_d = beat_q;
    if (pop) begin
      beat_d = m_last ? '0 : beat_q + 1'b1;
    end

    state_d = state_q;
    timer_d = '0;
    case (state_q)
      IDLE: begin
        if (inflight_q) state_d = ACTIVE;
      end
      ACTIVE: begin
        if (timer_q == TIMER_MAX) begin
          state_d = FLUSH;
        end else begin
          if (head_held && !inflight_q && fifo_empty) timer_d = timer_q + 1'b1;
          if (pop && m_last && (count_d == 2'd0)) state_d = IDLE;
        end
      end
      FLUSH: begin
        if (pop) state_d = (count_d != 2'd0) ? ACTIVE : IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q    <= IDLE;
      buf0_q     <= '0;
      buf1_q     <= '0;
      count_q    <= 2'd0;
      inflight_q <= 1'b0;
      beat_q     <= '0;
      timer_q    <= '0;
    end else begin
      state_q    <= state_d;
      buf0_q     <= buf0_d;
      buf1_q     <= buf1_d;
      count_q    <= count_d;
      inflight_q <= inflight_d;
      beat_q     <= beat_d;
      timer_q    <= timer_d;
    end
  end
endmodule
